maxpool_stream_ctrl: RTL and testbench

MAXPOOL_STREAM_CTRL -- requirements
Module: maxpool_stream_ctrl

---
 rtl/maxpool_stream_ctrl.sv | 140 ++++++++++++++
 tb/tb_maxpool_stream_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream_ctrl.sv
// 2x2 stride-2 max pooling over a streamed CH x DIM x DIM frame.
// Raster-order pixels in, pooled values out with valid/ready flow control.
module maxpool_stream_ctrl #(
    parameter int bitwidth = 16,
    parameter int CH       = 2,
    parameter int DIM      = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [bitwidth-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [bitwidth-1:0] out_data,
    output logic                       out_last
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int HW = (CH > 1) ? $clog2(CH) : 1;
    localparam int LW = (DIM / 2 > 1) ? $clog2(DIM / 2) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] col, row;
    logic [HW-1:0] ch;
    logic [LW-1:0] lidx;

    logic signed [bitwidth-1:0] pair;
    logic signed [bitwidth-1:0] pmax;
    logic signed [bitwidth-1:0] lbv;
    logic signed [bitwidth-1:0] res;
    logic signed [bitwidth-1:0] lbuf [DIM/2];

    logic acc, out_acc, load, last_pix;
    logic col_end, row_end, ch_end;

    // Handshake qualifiers, window position flags and the compare datapath.
    always_comb begin
        acc      = in_valid && in_ready;
        out_acc  = out_valid && out_ready;
        col_end  = (col == CW'(DIM - 1));
        row_end  = (row == CW'(DIM - 1));
        ch_end   = (ch == HW'(CH - 1));
        last_pix = col_end && row_end && ch_end;
        load     = acc && col[0] && row[0];
        lidx     = LW'(col >> 1);
        lbv      = lbuf[lidx];
        // Strict greater keeps the earlier sample on ties.
        pmax     = (in_data > pair) ? in_data : pair;
        res      = (pmax > lbv) ? pmax : lbv;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and control outputs.
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        in_ready = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                // Accept only if the output register can take a new result.
                in_ready = !(out_valid && !out_ready);
                if (acc && last_pix) state_nx = DRAIN;
            end
            DRAIN: begin
                if (out_acc && out_last) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Position of the next expected pixel: col, then row, then channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (state == IDLE) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (acc) begin
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row <= '0;
                    ch  <= ch_end ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Pair register and line buffer; always rewritten before being read.
    always_ff @(posedge clk) begin
        if (acc && !col[0]) pair <= in_data;
        if (acc && col[0] && !row[0]) lbuf[lidx] <= pmax;
    end

    // Output register: loads on a window's bottom-right pixel, holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= last_pix;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Directed bench for maxpool_stream_ctrl: ramp, tie/sign, stall,
// random gaps, mid-frame reset and start-while-busy scenarios.
module tb_maxpool_stream_ctrl;

    localparam int NPIX = 200;
    localparam int NOUT = 50;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic in_valid, in_ready, out_valid, out_ready, out_last;
    logic signed [15:0] in_data, out_data;

    logic signed [15:0] frame [NPIX];
    logic signed [15:0] outq [$];
    logic lastq [$];
    int npix, ndone;
    int checks = 0;
    int errors = 0;

    maxpool_stream_ctrl #(.bitwidth(16), .CH(2), .DIM(10)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Record transfers that will happen at the coming rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            outq.push_back(out_data);
            lastq.push_back(out_last);
        end
        if (in_valid && in_ready) npix++;
        if (done) ndone++;
    end

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] model(input int k);
        int c, i, j, b;
        logic signed [15:0] m;
        c = k / 25;
        i = (k % 25) / 5;
        j = k % 5;
        b = c * 100 + 20 * i + 2 * j;
        m = frame[b];
        if (frame[b+1] > m) m = frame[b+1];
        if (frame[b+10] > m) m = frame[b+10];
        if (frame[b+11] > m) m = frame[b+11];
        return m;
    endfunction

    function automatic logic signed [15:0] ramp_exp(input int k);
        int i, j;
        i = (k % 25) / 5;
        j = k % 5;
        if (k < 25) return 16'(10 * (2 * i + 1) + 2 * j + 1);
        return 16'(-(20 * i + 2 * j));
    endfunction

    task automatic fill_random();
        for (int p = 0; p < NPIX; p++) frame[p] = 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
    endtask

    task automatic run_frame(input int stall_at, input int abort_at,
                             input int start_at, input bit rnd);
        int sent = 0;
        int cyc = 0;
        bit stalled = 0;
        bit spulsed = 0;
        bit aborted = 0;
        bit a;
        int p, r, c, k;
        logic signed [15:0] held;
        outq.delete();
        lastq.delete();
        npix = 0;
        ndone = 0;
        chk("idle_busy", busy, 0);
        start = 1;
        tick();
        start = 0;
        chk("busy_after_start", busy, 1);
        while ((sent < NPIX || ndone == 0) && cyc < 5000) begin
            in_valid = (sent < NPIX) && (!rnd || $urandom_range(0, 2) != 0);
            in_data = frame[(sent < NPIX) ? sent : 0];
            out_ready = !rnd || $urandom_range(0, 3) != 0;
            start = 0;
            if (start_at >= 0 && sent == start_at && !spulsed) begin
                start = 1;
                spulsed = 1;
            end
            if (stall_at >= 0 && !stalled && out_valid &&
                outq.size() == stall_at) begin
                stalled = 1;
                out_ready = 0;
                in_valid = (sent < NPIX);
                held = out_data;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_data", out_data, held);
                    tick();
                end
                out_ready = 1;
            end
            @(negedge clk);
            a = in_valid && in_ready;
            tick();
            cyc++;
            if (a) begin
                p = sent;
                r = (p % 100) / 10;
                c = p % 10;
                if (r[0] && c[0]) begin
                    k = (p / 100) * 25 + (r / 2) * 5 + c / 2;
                    chk("latency_valid", out_valid, 1);
                    chk("latency_data", out_data, model(k));
                end
                sent++;
            end
            if (abort_at >= 0 && sent == abort_at) begin
                aborted = 1;
                break;
            end
        end
        in_valid = 0;
        start = 0;
        out_ready = 1;
        if (aborted) begin
            rst = 1;
            repeat (3) check_reset_outs();
            tick();
            rst = 0;
            repeat (3) tick();
            chk("post_rst_busy", busy, 0);
            chk("post_rst_in_ready", in_ready, 0);
        end else begin
            chk("frame_timeout", (cyc < 5000), 1);
        end
    endtask

    task automatic check_frame(input bit use_ramp);
        chk("out_count", outq.size(), NOUT);
        chk("pix_count", npix, NPIX);
        chk("done_count", ndone, 1);
        chk("busy_end", busy, 0);
        if (outq.size() == NOUT) begin
            for (int k = 0; k < NOUT; k++) begin
                chk("out_value", outq[k],
                    use_ramp ? ramp_exp(k) : model(k));
                chk("out_last", lastq[k], (k == NOUT - 1));
            end
        end
    endtask

    initial begin
        rst = 1;
        start = 0;
        in_valid = 0;
        in_data = 0;
        out_ready = 0;
        npix = 0;
        ndone = 0;
        repeat (2) check_reset_outs();
        tick();
        rst = 0;
        out_ready = 1;
        tick();

        // Ramp frame
        for (int p = 0; p < NPIX; p++)
            frame[p] = (p < 100) ? 16'(p) : 16'(-(p - 100));
        run_frame(-1, -1, -1, 0);
        check_frame(1);

        // Tie and sign windows
        fill_random();
        frame[0] = -16'sd5;
        frame[1] = -16'sd5;
        frame[10] = -16'sd32768;
        frame[11] = -16'sd5;
        frame[2] = 16'sd32767;
        frame[3] = -16'sd1;
        frame[12] = 16'sd0;
        frame[13] = 16'sd1;
        run_frame(-1, -1, -1, 0);
        chk("tie_window", (outq.size() > 0) ? outq[0] : 0, -5);
        chk("sign_window", (outq.size() > 1) ? outq[1] : 0, 32767);
        check_frame(0);

        // Backpressure
        fill_random();
        run_frame(7, -1, -1, 0);
        check_frame(0);

        // Random gaps
        fill_random();
        run_frame(-1, -1, -1, 1);
        check_frame(0);

        // Mid-frame reset, then a clean frame
        fill_random();
        run_frame(-1, 38, -1, 0);
        fill_random();
        run_frame(-1, -1, -1, 1);
        check_frame(0);

        // Start while busy is ignored
        fill_random();
        run_frame(-1, -1, 100, 0);
        check_frame(0);
        repeat (5) tick();
        chk("restart_in_ready", in_ready, 0);
        chk("restart_busy", busy, 0);
        chk("restart_pix", npix, NPIX);
        chk("restart_done", ndone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
